dac_write_arbiter: RTL and testbench
====================================

Name: dac_write_arbiter

Overview:
- Shares the single DAC FIFO write port among NUM_CH data_processor-style producers.
- Each producer presents a valid word and gets a one-cycle ack when its word is written.
- Round-robin arbitration with an optional burst hold, per-channel enable mask, and per-channel saturating accept counters readable through a select port.
- Sits between the per-channel processors and the DAC FIFO (full_dac / wr_dac / dac_fifo_in side).

Parameters:
NUM_CH, 4, number of requesting channels (2..8)
DW, 32, data word width
BURST_MAX, 4, max consecutive grants to one channel while it keeps requesting (1 = pure round-robin)
CNT_W, 16, width of each accept counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset; rst=0 clears all state immediately
req  input  NUM_CH  per-channel write request; bit i set = req_data word i valid
req_data  input  NUM_CH*DW  packed words, channel i at bits [i*DW +: DW]
ack  output  NUM_CH  one-hot; bit i high in the cycle channel i's word is written
ch_en  input  NUM_CH  channel enable mask; disabled channels are never granted
full_dac  input  1  DAC FIFO full
wr_dac  output  1  DAC FIFO write strobe
dac_fifo_in  output  DW  word written to the DAC FIFO
cur_ch  output  clog2(NUM_CH)  index of the channel granted this cycle (0 when idle)
clr_cnt  input  1  synchronous clear of all accept counters
cnt_sel  input  clog2(NUM_CH)  counter read select
cnt_out  output  CNT_W  registered value of the selected counter
busy  output  1  high while a burst is held (held-channel state)

Behaviour:
- Reset (rst=0): rr_ptr=0, burst_cnt=0, state=IDLE, all counters=0, cnt_out=0. Combinational outputs then evaluate to ack=0, wr_dac=0, dac_fifo_in=0, cur_ch=0, busy=0 while req=0.
- Eligible set: E = req & ch_en. wr_dac = |E & !full_dac. While full_dac=1: wr_dac=0, ack=0, and no state changes.
- Grant is combinational and zero-latency, so a producer sees ack in the same cycle its word is written.
  - dac_fifo_in = req_data of the granted channel, 0 when no grant.
  - ack[g] = wr_dac.
  - A producer must hold req/req_data stable until ack.
- State machine:
  - IDLE: grant the first eligible channel searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NUM_CH-1, 0, ...). On grant: hold_ch<=g, burst_cnt<=1. If BURST_MAX>1, go to HOLD. Otherwise rr_ptr<=(g+1) mod NUM_CH and stay in IDLE.
  - HOLD: if E[hold_ch] and burst_cnt<BURST_MAX, grant hold_ch again and increment burst_cnt. Otherwise perform the IDLE search from (hold_ch+1) mod NUM_CH in the same cycle (no bubble). A successful grant restarts the burst with burst_cnt=1. If nothing is eligible: rr_ptr<=(hold_ch+1) mod NUM_CH, go to IDLE.
  - When burst_cnt reaches BURST_MAX, the next grant must go to a different eligible channel if one exists. If none does, hold_ch may be re-granted with burst_cnt reset to 1.
- busy=1 in HOLD.
- ch_en deasserted on hold_ch mid-burst: treated as not eligible from that cycle onward.
- Full during HOLD: burst_cnt frozen; the burst resumes when full_dac clears.
- Counters: cnt[i] increments on ack[i] and saturates at 2^CNT_W-1. clr_cnt has priority over a same-cycle increment (result 0). cnt_out <= cnt[cnt_sel] each cycle, one-cycle read latency.
- Out-of-range cnt_sel (>= NUM_CH): cnt_out<=0.
- Reset mid-burst: async return to reset state. Nothing is acked after rst falls.

Test Plan:
- Reset: hold rst=0 with req=4'b1111, full_dac=0 -> wr_dac=0, ack=0, cnt_out=0. Release -> first ack on ch0 with dac_fifo_in=req_data[31:0], same cycle.
- Fairness: BURST_MAX=1, all four channels requesting continuously for 8 cycles -> ack sequence ch0,1,2,3,0,1,2,3. Each counter reads 2 via cnt_sel 0..3.
- Burst: BURST_MAX=4, ch1 and ch2 requesting -> ch1 acked 4 consecutive cycles, then ch2 for 4, then ch1. busy=1 throughout.
- Backpressure: full_dac=1 for 3 cycles mid-burst at burst_cnt=2 -> wr_dac=0 and no ack for 3 cycles. Then 2 more ch grants before rotation.
- Mask: ch_en=4'b1010, req=4'b1111 -> only ch1 and ch3 ever acked. Counters for ch0 and ch2 stay 0.
- Counters: CNT_W=4, 17 acks on ch0 -> cnt_out=15 (saturated). clr_cnt asserted together with an ack -> cnt_out=0 one cycle later. Reset asserted mid-burst -> all outputs drop asynchronously.

Source files
------------

// File: rtl/dac_write_arbiter.sv
// dac_write_arbiter: shares the single DAC FIFO write port among NUM_CH
// producers. Round-robin grant with an optional burst hold, a per-channel
// enable mask, and saturating per-channel accept counters behind a
// registered read-select port. The grant is combinational, so a producer
// sees its ack in the same cycle its word is written.
module dac_write_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int DW        = 32,
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = 16,
    localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int BC_W     = $clog2(BURST_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    req,
    input  logic [NUM_CH*DW-1:0] req_data,
    output logic [NUM_CH-1:0]    ack,
    input  logic [NUM_CH-1:0]    ch_en,
    input  logic                 full_dac,
    output logic                 wr_dac,
    output logic [DW-1:0]        dac_fifo_in,
    output logic [SEL_W-1:0]     cur_ch,
    input  logic                 clr_cnt,
    input  logic [SEL_W-1:0]     cnt_sel,
    output logic [CNT_W-1:0]     cnt_out,
    output logic                 busy
);

    typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]  hold_ch_q, hold_ch_d;
    logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_out_q;

    logic [NUM_CH-1:0] elig;
    logic              grant_vld;
    logic [SEL_W-1:0]  grant_idx;
    logic [SEL_W-1:0]  search_start;
    logic              search_found;
    logic [SEL_W-1:0]  search_idx;

    // Wrapping increment of a channel index.
    function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] ch);
        next_ch = (int'(ch) == NUM_CH - 1) ? '0 : ch + 1'b1;
    endfunction

    // Search for the first eligible channel, starting at search_start and wrapping.
    always_comb begin
        search_found = 1'b0;
        search_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            int j;
            j = (int'(search_start) + k) % NUM_CH;
            if (!search_found && elig[j]) begin
                search_found = 1'b1;
                search_idx   = SEL_W'(j);
            end
        end
    end

    // Grant selection and next-state logic; a full FIFO freezes everything.
    always_comb begin
        elig         = req & ch_en;
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        hold_ch_d    = hold_ch_q;
        burst_cnt_d  = burst_cnt_q;
        grant_vld    = 1'b0;
        grant_idx    = '0;
        search_start = (state_q == HOLD) ? next_ch(hold_ch_q) : rr_ptr_q;
        if (!full_dac) begin
            if (state_q == HOLD && elig[hold_ch_q] && burst_cnt_q < BC_W'(BURST_MAX)) begin
                // Continue the current burst on the held channel.
                grant_vld   = 1'b1;
                grant_idx   = hold_ch_q;
                burst_cnt_d = burst_cnt_q + 1'b1;
            end else if (search_found) begin
                // New burst; after an exhausted burst the held channel is
                // searched last, so it only wins when nobody else is eligible.
                grant_vld   = 1'b1;
                grant_idx   = search_idx;
                hold_ch_d   = search_idx;
                burst_cnt_d = BC_W'(1);
                if (BURST_MAX > 1) begin
                    state_d = HOLD;
                end else begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ch(search_idx);
                end
            end else if (state_q == HOLD) begin
                state_d  = IDLE;
                rr_ptr_d = next_ch(hold_ch_q);
            end
        end
    end

    // Write-side outputs; gated by reset so nothing is acked while rst is low.
    always_comb begin
        wr_dac      = grant_vld & rst;
        ack         = wr_dac ? (NUM_CH'(1) << grant_idx) : '0;
        dac_fifo_in = wr_dac ? req_data[int'(grant_idx)*DW +: DW] : '0;
        cur_ch      = wr_dac ? grant_idx : '0;
        busy        = (state_q == HOLD);
        cnt_out     = cnt_out_q;
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            hold_ch_q   <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_ch_q   <= hold_ch_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Per-channel counter next value: clear wins, otherwise saturating increment.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cnt
            assign cnt_d[gi] = clr_cnt ? '0 :
                               (ack[gi] && cnt_q[gi] != '1) ? cnt_q[gi] + 1'b1 :
                               cnt_q[gi];
        end
    endgenerate

    // Counter bank and registered read port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
            cnt_out_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
            if (int'(cnt_sel) < NUM_CH) cnt_out_q <= cnt_q[cnt_sel];
            else                        cnt_out_q <= '0;
        end
    end

endmodule

// File: tb/tb_dac_write_arbiter.sv
// Bench for dac_write_arbiter: two instances share stimulus, one with
// BURST_MAX=4/CNT_W=4 (burst + saturation) and one with BURST_MAX=1
// (pure round-robin). Expected grants come from a hand-derived vector
// table pushed through a scoreboard queue; counters are tracked from
// the expected grants.
module tb_dac_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]   ch_en = '1;
    logic           full_dac = 1'b0;
    logic           clr_cnt = 1'b0;
    logic [1:0]     cnt_sel = '0;

    logic [N-1:0]   ack_b, ack_r;
    logic           wr_b, wr_r;
    logic [DW-1:0]  dac_b, dac_r;
    logic [1:0]     cur_b, cur_r;
    logic [3:0]     cnt_out_b;
    logic [15:0]    cnt_out_r;
    logic           busy_b, busy_r;

    int checks = 0;
    int failures = 0;
    int exp_cnt_b [N];
    int exp_cnt_r [N];

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] en;
        logic         full;
        int           b;      // expected granted channel on burst DUT, -1 none
        int           r;      // expected granted channel on round-robin DUT
        logic         busy;   // expected busy on burst DUT
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    dac_write_arbiter #(.NUM_CH(N), .DW(DW), .BURST_MAX(4), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack_b),
        .ch_en(ch_en), .full_dac(full_dac), .wr_dac(wr_b), .dac_fifo_in(dac_b),
        .cur_ch(cur_b), .clr_cnt(clr_cnt), .cnt_sel(cnt_sel), .cnt_out(cnt_out_b),
        .busy(busy_b)
    );

    dac_write_arbiter #(.NUM_CH(N), .DW(DW), .BURST_MAX(1), .CNT_W(16)) dut_r (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack_r),
        .ch_en(ch_en), .full_dac(full_dac), .wr_dac(wr_r), .dac_fifo_in(dac_r),
        .cur_ch(cur_r), .clr_cnt(clr_cnt), .cnt_sel(cnt_sel), .cnt_out(cnt_out_r),
        .busy(busy_r)
    );

    function automatic logic [DW-1:0] word(input int i);
        word = 32'hC0DE_0000 + 32'(i) * 32'h0000_1111;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        oh = (i < 0) ? '0 : (N'(1) << i);
    endfunction

    function automatic logic [DW-1:0] wexp(input int i);
        wexp = (i < 0) ? '0 : word(i);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic addv(input logic [N-1:0] rq, input logic [N-1:0] en, input logic fl,
                        input int b, input int r, input logic bz);
        vec_t v;
        v.req = rq; v.en = en; v.full = fl; v.b = b; v.r = r; v.busy = bz;
        tbl.push_back(v);
    endtask

    task automatic bump(input int b, input int r);
        if (b >= 0 && exp_cnt_b[b] < 15)    exp_cnt_b[b]++;
        if (r >= 0 && exp_cnt_r[r] < 65535) exp_cnt_r[r]++;
    endtask

    // Drive table rows lo..hi; expected record goes into the scoreboard at drive time.
    task automatic run_rows(input int lo, input int hi);
        vec_t e;
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            req = tbl[i].req; ch_en = tbl[i].en; full_dac = tbl[i].full;
            sb.push_back(tbl[i]);
            #1;
            e = sb.pop_front();
            chk($sformatf("row%0d ack_b", i), 64'(ack_b), 64'(oh(e.b)));
            chk($sformatf("row%0d wr_b", i),  64'(wr_b),  64'(e.b >= 0));
            chk($sformatf("row%0d dac_b", i), 64'(dac_b), 64'(wexp(e.b)));
            chk($sformatf("row%0d cur_b", i), 64'(cur_b), 64'((e.b < 0) ? 0 : e.b));
            chk($sformatf("row%0d busy_b", i), 64'(busy_b), 64'(e.busy));
            chk($sformatf("row%0d ack_r", i), 64'(ack_r), 64'(oh(e.r)));
            chk($sformatf("row%0d dac_r", i), 64'(dac_r), 64'(wexp(e.r)));
            $display("row%0d req=%b en=%b full=%b ack_b=%b ack_r=%b busy_b=%b",
                     i, req, ch_en, full_dac, ack_b, ack_r, busy_b);
            bump(e.b, e.r);
        end
    endtask

    task automatic read_cnt(input int sel);
        @(negedge clk);
        req = '0; cnt_sel = 2'(sel);
        @(negedge clk);
        chk($sformatf("cnt_b[%0d]", sel), 64'(cnt_out_b), 64'(exp_cnt_b[sel]));
        chk($sformatf("cnt_r[%0d]", sel), 64'(cnt_out_r), 64'(exp_cnt_r[sel]));
        $display("cnt sel=%0d cnt_b=%0d cnt_r=%0d", sel, cnt_out_b, cnt_out_r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = '0; ch_en = '1; full_dac = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < N; i++) begin exp_cnt_b[i] = 0; exp_cnt_r[i] = 0; end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = word(i);
            exp_cnt_b[i] = 0; exp_cnt_r[i] = 0;
        end

        // Fairness / first-burst rows 0..7
        addv(4'hF, 4'hF, 0, 0, 0, 0); addv(4'hF, 4'hF, 0, 0, 1, 1);
        addv(4'hF, 4'hF, 0, 0, 2, 1); addv(4'hF, 4'hF, 0, 0, 3, 1);
        addv(4'hF, 4'hF, 0, 1, 0, 1); addv(4'hF, 4'hF, 0, 1, 1, 1);
        addv(4'hF, 4'hF, 0, 1, 2, 1); addv(4'hF, 4'hF, 0, 1, 3, 1);
        // Burst ch1/ch2 rows 8..16
        addv(4'h6, 4'hF, 0, 1, 1, 0); addv(4'h6, 4'hF, 0, 1, 2, 1);
        addv(4'h6, 4'hF, 0, 1, 1, 1); addv(4'h6, 4'hF, 0, 1, 2, 1);
        addv(4'h6, 4'hF, 0, 2, 1, 1); addv(4'h6, 4'hF, 0, 2, 2, 1);
        addv(4'h6, 4'hF, 0, 2, 1, 1); addv(4'h6, 4'hF, 0, 2, 2, 1);
        addv(4'h6, 4'hF, 0, 1, 1, 1);
        // Backpressure rows 17..23
        addv(4'h6, 4'hF, 0, 1, 2, 1);
        addv(4'h6, 4'hF, 1, -1, -1, 1); addv(4'h6, 4'hF, 1, -1, -1, 1);
        addv(4'h6, 4'hF, 1, -1, -1, 1);
        addv(4'h6, 4'hF, 0, 1, 1, 1); addv(4'h6, 4'hF, 0, 1, 2, 1);
        addv(4'h6, 4'hF, 0, 2, 1, 1);
        // Mask rows 24..29
        addv(4'hF, 4'hA, 0, 3, 3, 1); addv(4'hF, 4'hA, 0, 3, 1, 1);
        addv(4'hF, 4'hA, 0, 3, 3, 1); addv(4'hF, 4'hA, 0, 3, 1, 1);
        addv(4'hF, 4'hA, 0, 1, 3, 1); addv(4'hF, 4'hA, 0, 1, 1, 1);
        // Idle then single request rows 30..31
        addv(4'h0, 4'hF, 0, -1, -1, 1); addv(4'h1, 4'hF, 0, 0, 0, 0);

        // Reset held with all channels requesting: nothing may be written.
        req = 4'hF;
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst wr_b",  64'(wr_b),  64'(0));
        chk("rst ack_b", 64'(ack_b), 64'(0));
        chk("rst wr_r",  64'(wr_r),  64'(0));
        chk("rst cnt_b", 64'(cnt_out_b), 64'(0));
        chk("rst busy_b", 64'(busy_b), 64'(0));
        $display("reset held: wr_b=%b ack_b=%b cnt_b=%0d", wr_b, ack_b, cnt_out_b);
        @(posedge clk);
        #2 rst = 1'b1;

        run_rows(0, 7);
        for (int s = 0; s < N; s++) read_cnt(s);

        do_reset();
        run_rows(8, 31);
        for (int s = 0; s < N; s++) read_cnt(s);

        // Saturation: 17 more acks on ch0 (burst DUT counter is 4 bits).
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            req = 4'h1;
            #1;
            chk($sformatf("sat%0d ack_b", k), 64'(ack_b), 64'(4'h1));
            chk($sformatf("sat%0d ack_r", k), 64'(ack_r), 64'(4'h1));
            $display("sat%0d ack_b=%b ack_r=%b", k, ack_b, ack_r);
            bump(0, 0);
        end
        read_cnt(0);

        // Clear together with an ack: clear wins.
        @(negedge clk);
        req = 4'h1; clr_cnt = 1'b1;
        #1;
        chk("clr ack_b", 64'(ack_b), 64'(4'h1));
        for (int i = 0; i < N; i++) begin exp_cnt_b[i] = 0; exp_cnt_r[i] = 0; end
        @(negedge clk);
        req = '0; clr_cnt = 1'b0; cnt_sel = 2'd0;
        @(negedge clk);
        chk("clr cnt_b", 64'(cnt_out_b), 64'(0));
        chk("clr cnt_r", 64'(cnt_out_r), 64'(0));
        $display("clr: cnt_b=%0d cnt_r=%0d", cnt_out_b, cnt_out_r);
        read_cnt(1);

        // Reset mid-burst: outputs must drop without a clock edge.
        @(negedge clk);
        req = 4'hF; cnt_sel = 2'd1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("mid%0d wr_b", k), 64'(wr_b), 64'(1));
            chk($sformatf("mid%0d ack_b", k), 64'(ack_b), 64'(4'h2));
            @(negedge clk);
        end
        #1;
        chk("pre-rst busy_b", 64'(busy_b), 64'(1));
        chk("pre-rst cnt_b", 64'(cnt_out_b), 64'(2));
        #1 rst = 1'b0;
        #1;
        chk("async ack_b", 64'(ack_b), 64'(0));
        chk("async wr_b",  64'(wr_b),  64'(0));
        chk("async busy_b", 64'(busy_b), 64'(0));
        chk("async dac_b", 64'(dac_b), 64'(0));
        chk("async cur_b", 64'(cur_b), 64'(0));
        chk("async cnt_b", 64'(cnt_out_b), 64'(0));
        chk("async ack_r", 64'(ack_r), 64'(0));
        $display("async reset: ack_b=%b wr_b=%b busy_b=%b cnt_b=%0d", ack_b, wr_b, busy_b, cnt_out_b);
        @(posedge clk);
        #2 rst = 1'b1;
        req = '0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
